// File: rtl/fb_pkg.sv
// ============================================================================
//  Module      : fb_pkg
//  Description : Shared constants and types for the framebuffer arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fb_pkg;

    localparam int FB_ADDR_W = 15;
    localparam int FB_DATA_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_SCAN = 2'd1,
        OWN_HOST = 2'd2,
        OWN_MISS = 2'd3
    } fb_owner_t;

    // Control half of the host hold register; address/data live in separate
    // flops so their widths can follow the arbiter's parameters.
    typedef struct packed {
        logic hold_valid;
        logic we;
    } fb_hold_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones; cleared by sync reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

`default_nettype wire

// File: rtl/fb_arbiter.sv
// ============================================================================
//  Module      : fb_arbiter
//  Description : Single-port framebuffer RAM arbiter, scan-out priority with
//                bounded host wait.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W   = FB_ADDR_W,
    parameter int DATA_W   = FB_DATA_W,
    parameter int MAX_WAIT = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_valid,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_miss,
    output logic [7:0]        miss_count,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);

    fb_hold_t          hold_q, hold_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;

    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    // Two tag lanes: a host-read grant and a dropped scan can share a cycle.
    fb_owner_t         rd_tag1_q, rd_tag1_d, rd_tag2_q, rd_tag2_d;
    fb_owner_t         drop_tag1_q, drop_tag1_d, drop_tag2_q, drop_tag2_d;

    logic              scan_valid_q, scan_valid_d;
    logic              scan_miss_q, scan_miss_d;
    logic              host_rvalid_q, host_rvalid_d;
    logic [DATA_W-1:0] scan_data_q, scan_data_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

    logic              host_accept;
    logic              at_limit;
    logic              grant_scan;
    logic              grant_host;

    always_comb begin
        host_accept = host_valid && !hold_q.hold_valid;
        at_limit    = hold_q.hold_valid && (wait_cnt_q == c_max_wait);
        grant_scan  = scan_req && !at_limit;
        grant_host  = hold_q.hold_valid && (!scan_req || at_limit);

        hold_d       = hold_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        if (grant_host) begin
            hold_d.hold_valid = 1'b0;
        end
        if (host_accept) begin
            hold_d.hold_valid = 1'b1;
            hold_d.we         = host_we;
            hold_addr_d       = host_addr;
            hold_wdata_d      = host_wdata;
        end

        wait_cnt_d = wait_cnt_q;
        if (grant_host) begin
            wait_cnt_d = '0;
        end else if (grant_scan && hold_q.hold_valid) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end

        ram_en_d    = grant_scan || grant_host;
        ram_we_d    = grant_host && hold_q.we;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (grant_host) begin
            ram_addr_d = hold_addr_q;
            if (hold_q.we) begin
                ram_wdata_d = hold_wdata_q;
            end
        end else if (grant_scan) begin
            ram_addr_d = scan_addr;
        end

        rd_tag1_d = OWN_NONE;
        if (grant_scan) begin
            rd_tag1_d = OWN_SCAN;
        end else if (grant_host && !hold_q.we) begin
            rd_tag1_d = OWN_HOST;
        end
        drop_tag1_d = (grant_host && scan_req) ? OWN_MISS : OWN_NONE;
        rd_tag2_d   = rd_tag1_q;
        drop_tag2_d = drop_tag1_q;

        scan_valid_d  = (rd_tag2_q == OWN_SCAN);
        host_rvalid_d = (rd_tag2_q == OWN_HOST);
        scan_miss_d   = (drop_tag2_q == OWN_MISS);
        scan_data_d   = scan_valid_d  ? ram_rdata : scan_data_q;
        host_rdata_d  = host_rvalid_d ? ram_rdata : host_rdata_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_q        <= '0;
            hold_addr_q   <= '0;
            hold_wdata_q  <= '0;
            wait_cnt_q    <= '0;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            rd_tag1_q     <= OWN_NONE;
            rd_tag2_q     <= OWN_NONE;
            drop_tag1_q   <= OWN_NONE;
            drop_tag2_q   <= OWN_NONE;
            scan_valid_q  <= 1'b0;
            scan_miss_q   <= 1'b0;
            host_rvalid_q <= 1'b0;
            scan_data_q   <= '0;
            host_rdata_q  <= '0;
        end else begin
            hold_q        <= hold_d;
            hold_addr_q   <= hold_addr_d;
            hold_wdata_q  <= hold_wdata_d;
            wait_cnt_q    <= wait_cnt_d;
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            rd_tag1_q     <= rd_tag1_d;
            rd_tag2_q     <= rd_tag2_d;
            drop_tag1_q   <= drop_tag1_d;
            drop_tag2_q   <= drop_tag2_d;
            scan_valid_q  <= scan_valid_d;
            scan_miss_q   <= scan_miss_d;
            host_rvalid_q <= host_rvalid_d;
            scan_data_q   <= scan_data_d;
            host_rdata_q  <= host_rdata_d;
        end
    end

    sat_counter #(
        .WIDTH (8)
    ) u_miss_cnt (
        .clk     (clock),
        .rst     (reset),
        .i_inc   (scan_miss_d),
        .o_count (miss_count)
    );

    assign host_ready  = !hold_q.hold_valid;
    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign scan_valid  = scan_valid_q;
    assign scan_miss   = scan_miss_q;
    assign scan_data   = scan_data_q;
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;

endmodule

`default_nettype wire
